// File: rtl/dmem_responder_pkg.sv
// Shared memop encodings, FSM states and request legality check for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_RD,
    ST_STORE_WR,
    ST_RESP
  } state_e;

  // Op/alignment legality only; the address range check depends on the RAM depth.
  function automatic logic access_err(input logic [2:0] op, input logic we, input logic [1:0] off);
    logic err;
    case (op)
      MEMOP_LB:             err = 1'b0;
      MEMOP_LH:             err = off[0];
      MEMOP_LW:             err = |off;
      MEMOP_LBU, MEMOP_LHU: err = we | ((op == MEMOP_LHU) & off[0]);
      default:              err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core data port (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_op, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_op, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_byte_lane.sv
// Combinational byte-lane logic: load lane extraction/extension and sub-word store merge.
module dmem_byte_lane
  import dmem_responder_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [31:0] st_word_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = ld_word_i[7:0];
      2'd1:    byte_sel = ld_word_i[15:8];
      2'd2:    byte_sel = ld_word_i[23:16];
      default: byte_sel = ld_word_i[31:24];
    endcase
    half_sel = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    rdata_o = '0;
    case (op_i)
      MEMOP_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LBU: rdata_o = {24'h0, byte_sel};
      MEMOP_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      MEMOP_LHU: rdata_o = {16'h0, half_sel};
      MEMOP_LW:  rdata_o = ld_word_i;
      default:   rdata_o = '0;
    endcase
  end

  always_comb begin
    merged_o = st_word_i;
    case (op_i)
      MEMOP_LB: begin
        case (off_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      MEMOP_LH: begin
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      MEMOP_LW: merged_o = wdata_i;
      default:  merged_o = st_word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data RAM serving one load/store at a time over valid/ready request and response channels;
// sub-word stores are read-modify-write, and illegal/misaligned/out-of-range requests return err with no RAM access.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        merge_q, merge_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        mem_rdata;
  logic               mem_we;
  logic [31:0]        ld_data;
  logic [31:0]        st_data;
  logic               req_err;

  assign mem_rdata = mem[idx_q];

  // Legality is judged on the live request so an error can reach RESP at the accept edge.
  assign req_err = access_err(bus.req_op, bus.req_we, bus.req_addr[1:0])
                 | ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

  dmem_byte_lane u_lane (
    .ld_word_i (mem_rdata),
    .st_word_i (merge_q),
    .wdata_i   (wdata_q),
    .op_i      (op_q),
    .off_i     (off_q),
    .rdata_o   (ld_data),
    .merged_o  (st_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          idx_d   = bus.req_addr[IDX_W+1:2];
          off_d   = bus.req_addr[1:0];
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                   state_d = ST_RESP;
          else if (!bus.req_we)          state_d = ST_LOAD;
          else if (bus.req_op == MEMOP_LW) state_d = ST_STORE_WR;
          else                           state_d = ST_STORE_RD;
        end
      end
      ST_LOAD: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_STORE_RD: begin
        merge_d = mem_rdata;
        state_d = ST_STORE_WR;
      end
      ST_STORE_WR: begin
        mem_we  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write enable comes from state_q, so an asynchronous reset during STORE_WR drops the pending write.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= st_data;
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
